// File: rtl/ssd_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_ctrl_if
// Description : Write handshake bundle for the seven-segment scan controller.
//               The requester (master) presents four hex digits plus four
//               decimal points and holds them until the controller (slave)
//               accepts them.
// Signals     : wr_valid  - write request (master -> slave)
//               wr_ready  - write accept  (slave  -> master)
//               wr_data   - 16-bit, four hex digits, [3:0] is digit 0
//               wr_dp     - 4-bit decimal points, bit i is digit i
// Revision    : 1.0 - initial release
// ============================================================================
interface ssd_scan_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_dp,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_dp,
        output wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_ctrl
// Description : Time-multiplexed driver for a four-digit seven-segment
//               display. Each digit owns a slot of DIV clocks; the first
//               BLANK clocks of every slot keep all anodes off to avoid
//               ghosting, the remainder drive the selected digit. New
//               contents are written into a shadow buffer and only copied to
//               the visible buffer at a frame boundary (or while idle), so
//               the display never changes mid-frame.
// Parameters  : DIV   - clocks per digit slot   (BLANK+2 .. 2^24-1)
//               BLANK - blanking clocks per slot (1 .. DIV-2)
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous reset, active-high
//               enable     - scan enable, low keeps the display dark
//               wr         - write handshake (ssd_scan_ctrl_if.slave)
//               segment    - abcdefg, a = MSB, active-high
//               dp         - decimal point of the driven digit
//               anode      - one-hot active-low digit select
//               frame_done - one-cycle pulse at the end of digit-3's slot
// Macros      : SSD_LZB_EN - leading-zero blanking of digits 1..3
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_ctrl #(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            enable,
    ssd_scan_ctrl_if.slave       wr,
    output logic [6:0]           segment,
    output logic                 dp,
    output logic [3:0]           anode,
    output logic                 frame_done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              C_CW             = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [C_CW-1:0] C_CNT_LAST       = C_CW'(DIV - 1);
    localparam logic [C_CW-1:0] C_CNT_BLANK_LAST = C_CW'(BLANK - 1);
    localparam logic [C_CW-1:0] C_CNT_ONE        = C_CW'(1);
    localparam logic [C_CW-1:0] C_CNT_ZERO       = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic [C_CW-1:0]   cnt_q,       cnt_d;
    logic [1:0]        idx_q,       idx_d;
    logic [15:0]       disp_q,      disp_d;
    logic [3:0]        disp_dp_q,   disp_dp_d;
    logic [15:0]       shadow_q,    shadow_d;
    logic [3:0]        shadow_dp_q, shadow_dp_d;
    logic              pending_q,   pending_d;

    logic              w_frame_done;
    logic              w_accept;
    logic              w_commit;
    logic [3:0]        w_nibble;
    logic              w_lz_blank;

    // ------------------------------------------------------------------------
    // Hex digit to abcdefg segment pattern
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h7E;
            4'h1:    seg = 7'h30;
            4'h2:    seg = 7'h6D;
            4'h3:    seg = 7'h79;
            4'h4:    seg = 7'h33;
            4'h5:    seg = 7'h5B;
            4'h6:    seg = 7'h5F;
            4'h7:    seg = 7'h70;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h7B;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h1F;
            4'hC:    seg = 7'h4E;
            4'hD:    seg = 7'h3D;
            4'hE:    seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= C_CNT_ZERO;
            idx_q       <= 2'd0;
            disp_q      <= 16'h0000;
            disp_dp_q   <= 4'h0;
            shadow_q    <= 16'h0000;
            shadow_dp_q <= 4'h0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pending_q   <= pending_d;
        end
    end

    // ------------------------------------------------------------------------
    // Scan sequencer: slot counter, digit index and phase within the slot
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = C_CNT_ZERO;
                idx_d = 2'd0;
                if (enable) begin
                    state_d = ST_BLANK;
                end
            end

            ST_BLANK: begin
                // The counter keeps running across the BLANK->DRIVE edge so
                // that DRIVE starts at count BLANK.
                cnt_d = cnt_q + C_CNT_ONE;
                if (cnt_q == C_CNT_BLANK_LAST) begin
                    state_d = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                if (cnt_q == C_CNT_LAST) begin
                    cnt_d   = C_CNT_ZERO;
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_BLANK;
                end else begin
                    cnt_d   = cnt_q + C_CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = C_CNT_ZERO;
                idx_d   = 2'd0;
            end
        endcase

        // Dropping enable abandons the slot in progress from any state.
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = C_CNT_ZERO;
            idx_d   = 2'd0;
        end
    end

    assign w_frame_done = (state_q == ST_DRIVE) && (idx_q == 2'd3) &&
                          (cnt_q == C_CNT_LAST);

    // ------------------------------------------------------------------------
    // Double buffer. Accept needs pending=0 and commit needs pending=1, so the
    // two can never coincide and the shadow is never overwritten unseen.
    // ------------------------------------------------------------------------
    assign w_accept = wr.wr_valid && !pending_q;
    assign w_commit = pending_q && (w_frame_done || (state_q == ST_IDLE));

    always_comb begin
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pending_d   = pending_q;

        if (w_commit) begin
            disp_d    = shadow_q;
            disp_dp_d = shadow_dp_q;
            pending_d = 1'b0;
        end

        if (w_accept) begin
            shadow_d    = wr.wr_data;
            shadow_dp_d = wr.wr_dp;
            pending_d   = 1'b1;
        end
    end

    assign wr.wr_ready = !pending_q;

    // ------------------------------------------------------------------------
    // Digit selection and optional leading-zero blanking
    // ------------------------------------------------------------------------
    always_comb begin
        case (idx_q)
            2'd0:    w_nibble = disp_q[3:0];
            2'd1:    w_nibble = disp_q[7:4];
            2'd2:    w_nibble = disp_q[11:8];
            default: w_nibble = disp_q[15:12];
        endcase
    end

`ifdef SSD_LZB_EN
    // A digit is blanked when it and every more significant digit are zero;
    // digit 0 always shows so a zero value still reads "0".
    always_comb begin
        case (idx_q)
            2'd1:    w_lz_blank = (disp_q[15:4]  == 12'h000);
            2'd2:    w_lz_blank = (disp_q[15:8]  == 8'h00);
            2'd3:    w_lz_blank = (disp_q[15:12] == 4'h0);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs: purely from registered state, never from the write inputs
    // ------------------------------------------------------------------------
    always_comb begin
        anode      = 4'b1111;
        segment    = 7'h00;
        dp         = 1'b0;
        frame_done = w_frame_done;

        if (state_q == ST_DRIVE) begin
            anode   = ~(4'b0001 << idx_q);
            segment = w_lz_blank ? 7'h00 : f_hex_to_seg(w_nibble);
            dp      = disp_dp_q[idx_q];
        end
    end

endmodule
`default_nettype wire

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 Parameter: DIV, 100000, clk cycles per digit slot; legal range BLANK+2..2^24-1.
REQ-002 Parameter: BLANK, 1000, blanking cycles at start of each slot; legal range 1..DIV-2.
REQ-003 Port: clk  in  1  clock, all state on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: enable  in  1  scan enable; low = display dark.
REQ-006 Port: wr_valid  in  1  write request.
REQ-007 Port: wr_ready  out  1  write accept; transfer when wr_valid && wr_ready on a clk edge.
REQ-008 Port: wr_data  in  16  four hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-009 Port: wr_dp  in  4  decimal point per digit, bit i is digit i.
REQ-010 Port: segment  out  7  abcdefg, a = MSB, active-high.
REQ-011 Port: dp  out  1  decimal point of the driven digit, active-high.
REQ-012 Port: anode  out  4  digit select, one-hot active-low; 4'b1111 = none.
REQ-013 Port: frame_done  out  1  one-cycle pulse at the end of each digit-3 slot.

Function
REQ-014 FSM states are IDLE, BLANK, and DRIVE; a slot counter runs 0..DIV-1 and a digit index runs 0..3.
REQ-015 IDLE: anode=1111, segment=0, dp=0, slot counter=0, index=0; when enable=1, go to BLANK next cycle.
REQ-016 BLANK covers slot counts 0..BLANK-1: anode=1111, segment=0, dp=0.
REQ-017 DRIVE covers slot counts BLANK..DIV-1: anode[index]=0 with other bits 1, segment=decode(display[index]), dp=display_dp[index].
REQ-018 At slot count DIV-1: counter returns to 0, index increments mod 4, next state BLANK.
REQ-019 frame_done=1 only in the cycle with index=3 and slot count=DIV-1 in DRIVE.
REQ-020 enable=0 in any state forces IDLE next cycle, abandoning the current slot.
REQ-021 Decode (hex to segment, in hex): 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 B:1F C:4E D:3D E:4F F:47.
REQ-022 Outputs are combinational from registered state, index, and display registers only; they have no dependency on wr_* inputs.
REQ-023 Double buffering: an accepted write is loaded into the shadow registers (data and dp) and sets pending=1.
REQ-024 wr_ready = !pending.
REQ-025 In the frame_done cycle with pending=1, the shadow is copied to display and pending clears; wr_ready=1 from the next cycle.
REQ-026 In IDLE with pending=1, the commit occurs on the next clk edge.
REQ-027 The display therefore never changes mid-frame while scanning.
REQ-028 A write presented while pending=1 is held off (not dropped); the requester keeps wr_valid and wr_data stable until accepted.

Reset
REQ-029 rst=1 asynchronously sets: state=IDLE, counter=0, index=0, display=0, display_dp=0, shadow=0, pending=0.
REQ-030 Outputs during and after reset: anode=1111, segment=0, dp=0, frame_done=0, wr_ready=1.
REQ-031 Reset mid-frame discards any pending write; after release, scanning restarts at digit 0 in BLANK if enable=1.

Configuration
REQ-032 Macro SSD_LZB_EN enables leading-zero blanking.
REQ-033 With SSD_LZB_EN: during a digit-i DRIVE (i=1..3), segment=0 when display[i] and all higher digits are 0; anode and dp still follow REQ-017.
REQ-034 With SSD_LZB_EN: digit 0 is never blanked.
REQ-035 Without SSD_LZB_EN: all digits decode per REQ-021.

Verification (DIV=10, BLANK=2)
REQ-036 Reset, then enable=1: anode=1111 for 1 IDLE cycle plus 2 BLANK cycles, then 1110 for 8 cycles, 1111 for 2, then 1101; frame_done pulses every 40 cycles.
REQ-037 Write 16'h1234 mid-frame: wr_ready=0 until the cycle after frame_done; next frame digit 0 shows 33, digit 3 shows 30.
REQ-038 Second write 16'hABCD while pending: held off until the first write commits, then accepted; data displays one frame later.
REQ-039 enable dropped during a digit-2 DRIVE: next cycle anode=1111 and segment=0; a pending write commits one cycle later; re-enable restarts at digit 0.
REQ-040 Write 16'h0005 with SSD_LZB_EN: digits 3..1 DRIVE with segment=00 and digit 0 shows 5B; without the macro, digits 3..1 show 7E.
REQ-041 Assert rst mid-frame with a write pending: outputs are immediately at reset values, wr_ready=1, and the display stays 0 after release.
